sevenseg_scan: RTL

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/sevenseg_scan.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// ============================================================================
// sevenseg_scan : time-multiplexed common-anode 7-segment driver, tear-free load
// Optional: define SEVENSEG_LZB_EN for leading-zero blanking.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sevenseg_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic [NUM_DIGITS-1:0]     dp_i,
   input  logic                      load_i,
   input  logic                      hex_mode_i,
   output logic [6:0]                seg_o,
   output logic                      dp_o,
   output logic [NUM_DIGITS-1:0]     an_o,
   output logic                      frame_o
);

   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DISP_W = 5 * NUM_DIGITS;
   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]      div_q, div_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DISP_W-1:0]     disp_q, disp_d;
   logic [DISP_W-1:0]     pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_q, frame_d;

   logic                  w_slot_end;
   logic                  w_wrap;
   logic [3:0]            w_nib;
   logic                  w_dp_bit;

   function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
         4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
         4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
         4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
      endcase
      if (!hex && nib > 4'd9) g = 7'h7F;
      return g;
   endfunction

   // Display image only changes at the frame wrap; a load on that very cycle goes straight in.
   always_comb begin
      w_slot_end = (div_q == C_DIV_LAST);
      w_wrap     = w_slot_end && (idx_q == C_IDX_LAST);
      div_d      = w_slot_end ? '0 : div_q + 1'b1;
      idx_d      = idx_q;
      if (w_slot_end) idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (w_wrap) begin
         if (load_i)          disp_d = {value_i, dp_i};
         else if (pend_vld_q) disp_d = pend_q;
         pend_vld_d = 1'b0;
      end else if (load_i) begin
         pend_d     = {value_i, dp_i};
         pend_vld_d = 1'b1;
      end
   end

`ifdef SEVENSEG_LZB_EN
   logic [NUM_DIGITS-1:0] w_blank;
   logic                  w_zero_run;
   logic                  w_blank_sel;
`endif

   always_comb begin
      w_nib    = '0;
      w_dp_bit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            w_nib    = disp_q[NUM_DIGITS + 4*i +: 4];
            w_dp_bit = disp_q[i];
         end
      end
`ifdef SEVENSEG_LZB_EN
      // A digit blanks when it and everything to its left are zero.
      w_zero_run  = 1'b1;
      w_blank     = '0;
      w_blank_sel = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (disp_q[NUM_DIGITS + 4*i +: 4] == 4'h0);
         w_blank[i] = w_zero_run && (i > 0);
         if (idx_q == IDX_W'(i)) w_blank_sel = w_blank[i];
      end
`endif
      seg_d = glyph(w_nib, hex_mode_i);
`ifdef SEVENSEG_LZB_EN
      if (w_blank_sel) seg_d = 7'h7F;
`endif
      dp_d = ~w_dp_bit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_d[i] = !((div_q != '0) && (idx_q == IDX_W'(i)));
      end
      frame_d = (div_q == '0) && (idx_q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         an_q       <= '1;
         frame_q    <= 1'b0;
      end else begin
         div_q      <= div_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         frame_q    <= frame_d;
      end
   end

   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   assign frame_o = frame_q;

endmodule

`default_nettype wire
